// File: rtl/codec_cfg_pkg.sv
`default_nettype none
// ============================================================================
// codec_cfg_pkg : shared types, register map and init table of the codec
//                 configuration sequencer.
// Revision      : 1.0
// ============================================================================
package codec_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_PWR  = 3'd1,
    ISSUE     = 3'd2,
    WAIT_RESP = 3'd3,
    GAP       = 3'd4,
    DONE      = 3'd5,
    FAIL      = 3'd6
  } state_e;

  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned DATA_W   = 9;
  localparam int unsigned CMD_W    = ADDR_W + DATA_W;
  localparam int unsigned NUM_CMDS = 11;
  localparam int unsigned IDX_W    = 4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CMDS - 1);

  localparam logic [ADDR_W-1:0] REG_LIN    = 7'h00;
  localparam logic [ADDR_W-1:0] REG_RIN    = 7'h01;
  localparam logic [ADDR_W-1:0] REG_LHP    = 7'h02;
  localparam logic [ADDR_W-1:0] REG_RHP    = 7'h03;
  localparam logic [ADDR_W-1:0] REG_APATH  = 7'h04;
  localparam logic [ADDR_W-1:0] REG_DPATH  = 7'h05;
  localparam logic [ADDR_W-1:0] REG_POWER  = 7'h06;
  localparam logic [ADDR_W-1:0] REG_IFACE  = 7'h07;
  localparam logic [ADDR_W-1:0] REG_SRATE  = 7'h08;
  localparam logic [ADDR_W-1:0] REG_ACTIVE = 7'h09;
  localparam logic [ADDR_W-1:0] REG_RESET  = 7'h0F;

  function automatic logic [CMD_W-1:0] cmd_word(input logic [ADDR_W-1:0] addr,
                                                input logic [DATA_W-1:0] data);
    cmd_word = {addr, data};
  endfunction

  // Entry 0 must stay the codec soft reset: it is followed by a power-up wait.
  function automatic logic [CMD_W-1:0] init_word(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    init_word = cmd_word(REG_RESET,  9'h000);
      4'd1:    init_word = cmd_word(REG_POWER,  9'h000);
      4'd2:    init_word = cmd_word(REG_LIN,    9'h017);
      4'd3:    init_word = cmd_word(REG_RIN,    9'h017);
      4'd4:    init_word = cmd_word(REG_LHP,    9'h079);
      4'd5:    init_word = cmd_word(REG_RHP,    9'h079);
      4'd6:    init_word = cmd_word(REG_APATH,  9'h012);
      4'd7:    init_word = cmd_word(REG_DPATH,  9'h000);
      4'd8:    init_word = cmd_word(REG_IFACE,  9'h04A);
      4'd9:    init_word = cmd_word(REG_SRATE,  9'h000);
      4'd10:   init_word = cmd_word(REG_ACTIVE, 9'h001);
      default: init_word = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/codec_init_sequencer_if.sv
`default_nettype none
// ============================================================================
// codec_init_sequencer_if : command/response link between the init sequencer
//                           (master) and the serial config engine (slave).
// Revision                : 1.0
// ============================================================================
interface codec_init_sequencer_if;
  logic                           cmd_valid;
  logic                           cmd_ready;
  logic [codec_cfg_pkg::CMD_W-1:0] cmd_data;
  logic                           resp_valid;
  logic                           resp_nack;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ready,
    input  resp_valid,
    input  resp_nack
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ready,
    output resp_valid,
    output resp_nack
  );
endinterface
`default_nettype wire

// File: rtl/delay_counter.sv
`default_nettype none
// ============================================================================
// delay_counter : loadable down-counter; expired_o is high during the last
//                 counted cycle, after which the counter idles.
// Revision      : 1.0
// ============================================================================
module delay_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  wire             clk_i,
  input  wire             rst_ni,
  input  wire             load_i,
  input  wire [WIDTH-1:0] value_i,
  output logic            running_o,
  output logic            expired_o
);

  logic [WIDTH-1:0] count_q;
  logic             run_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else if (load_i) begin
      count_q <= value_i;
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (expired_o) begin
        count_q <= '0;
        run_q   <= 1'b0;
      end else begin
        count_q <= count_q - WIDTH'(1);
      end
    end
  end

  assign running_o = run_q;
  assign expired_o = run_q && (count_q <= WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/codec_init_sequencer.sv
`default_nettype none
// ============================================================================
// codec_init_sequencer : walks the codec init table, one handshaked write per
//                        entry, with NACK retry, settle gaps and status flags.
// Revision             : 1.0
// ============================================================================
module codec_init_sequencer
  import codec_cfg_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned POWERUP_CYCLES = CLK_HZ / 100,
  parameter int unsigned GAP_CYCLES     = CLK_HZ / 10_000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  wire                    clk_clk,
  input  wire                    reset_reset_n,
  input  wire                    start,
  codec_init_sequencer_if.master cmd_if,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [IDX_W-1:0]       cmd_index
);

  localparam int unsigned MAX_DLY = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_DLY) + 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [CNT_W-1:0]   PWR_LOAD  = CNT_W'(POWERUP_CYCLES);
  localparam logic [CNT_W-1:0]   GAP_LOAD  = CNT_W'(GAP_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

  state_e             state_q;
  logic               cmd_valid_q;
  logic [CMD_W-1:0]   cmd_data_q;
  logic [IDX_W-1:0]   cmd_index_q;
  logic [RETRY_W-1:0] retry_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;

  logic               dly_load;
  logic [CNT_W-1:0]   dly_value;
  logic               dly_running;
  logic               dly_expired;

  // The counter arms itself in the first cycle of a waiting state, which also
  // covers the post-reset power-up wait without a dedicated reset path.
  always_comb begin
    dly_load  = 1'b0;
    dly_value = PWR_LOAD;
    if (!dly_running && (state_q == WAIT_PWR || state_q == GAP)) begin
      dly_load  = 1'b1;
      dly_value = (state_q == GAP) ? GAP_LOAD : PWR_LOAD;
    end
  end

  delay_counter #(
    .WIDTH (CNT_W)
  ) u_delay (
    .clk_i     (clk_clk),
    .rst_ni    (reset_reset_n),
    .load_i    (dly_load),
    .value_i   (dly_value),
    .running_o (dly_running),
    .expired_o (dly_expired)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= WAIT_PWR;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      cmd_index_q <= '0;
      retry_q     <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_q <= WAIT_PWR;

        WAIT_PWR, GAP: begin
          if (dly_expired) begin
            state_q     <= ISSUE;
            cmd_valid_q <= 1'b1;
            cmd_data_q  <= init_word(cmd_index_q);
          end
        end

        ISSUE: begin
          if (cmd_valid_q && cmd_if.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (cmd_if.resp_valid) begin
            if (!cmd_if.resp_nack) begin
              if (cmd_index_q == LAST_IDX) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                cmd_index_q <= cmd_index_q + 4'd1;
                retry_q     <= '0;
                // The codec needs a full power-up settle after its soft reset.
                state_q     <= (cmd_index_q == 4'd0) ? WAIT_PWR : GAP;
              end
            end else if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + RETRY_W'(1);
              state_q <= GAP;
            end else begin
              state_q <= FAIL;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end

        DONE, FAIL: begin
          if (start) begin
            state_q     <= IDLE;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cmd_index_q <= '0;
            retry_q     <= '0;
          end
        end

        default: state_q <= WAIT_PWR;
      endcase
    end
  end

  assign cmd_if.cmd_valid = cmd_valid_q;
  assign cmd_if.cmd_data  = cmd_data_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;
  assign cmd_index        = cmd_index_q;

endmodule
`default_nettype wire

// File: tb/tb_codec_init_sequencer.sv
`default_nettype none
// ============================================================================
// tb_codec_init_sequencer : directed bench with a config-master model and a
//                           scoreboard of expected command words.
// Revision                : 1.0
// ============================================================================
module tb_codec_init_sequencer;

  localparam int PWR       = 20;
  localparam int GAPC      = 4;
  localparam int MAX_RETRY = 3;
  localparam int LAST      = 10;
  localparam int NONE      = -1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       error;
  logic [3:0] cmd_index;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] tbl [0:10] = '{16'h1E00, 16'h0C00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
                              16'h0812, 16'h0A00, 16'h0E4A, 16'h1000, 16'h1201};
  logic [15:0] sb [$];

  codec_init_sequencer_if cif ();

  codec_init_sequencer #(
    .CLK_HZ         (50_000_000),
    .POWERUP_CYCLES (PWR),
    .GAP_CYCLES     (GAPC),
    .MAX_RETRY      (MAX_RETRY)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .start         (start),
    .cmd_if        (cif),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .cmd_index     (cmd_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag, input bit e_done, input bit e_busy,
                              input bit e_err, input int e_idx);
    check({tag, "_done"}, done, e_done);
    check({tag, "_busy"}, busy, e_busy);
    check({tag, "_error"}, error, e_err);
    check({tag, "_index"}, cmd_index, e_idx);
  endtask

  // Words the DUT must issue, including retried entries.
  task automatic push_seq(input int nack_e, input int nack_n, input int last_e);
    for (int e = 0; e <= last_e; e++) begin
      int issues;
      issues = 1;
      if (e == nack_e) issues = (nack_n > MAX_RETRY) ? MAX_RETRY + 1 : nack_n + 1;
      for (int k = 0; k < issues; k++) sb.push_back(tbl[e]);
    end
  endtask

  task automatic wait_first_valid(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (cif.cmd_valid) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_status("restart", 1'b0, 1'b1, 1'b0, 0);
  endtask

  // Config-master model: accepts words, answers two cycles later.
  task automatic serve(input int stall_e, input int stall_n, input int nack_e, input int nack_n,
                       input int stop_e, input int bstart_e, input bit start_last);
    int entry = 0;
    int nacks = 0;
    int stalled = 0;
    int rdly = 0;
    bit rnack = 1'b0;
    bit stall_ok = 1'b1;
    bit stop_pend = 1'b0;
    bit ended = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      cif.cmd_ready  = 1'b0;
      cif.resp_valid = 1'b0;
      cif.resp_nack  = 1'b0;
      start          = 1'b0;
      if (stop_pend || done || error) begin
        ended = 1'b1;
        break;
      end
      if (rdly > 0) begin
        rdly--;
        if (rdly == 0) begin
          cif.resp_valid = 1'b1;
          cif.resp_nack  = rnack;
          if (!rnack) begin
            if (entry == bstart_e) start = 1'b1;
            if (entry == LAST && start_last) start = 1'b1;
            entry++;
          end
        end
      end else if (cif.cmd_valid) begin
        if (entry == stall_e && stalled < stall_n) begin
          stalled++;
          if (cif.cmd_data !== tbl[stall_e]) stall_ok = 1'b0;
        end else begin
          cif.cmd_ready = 1'b1;
          check("write_expected", sb.size() != 0, 1);
          if (sb.size() != 0) check("write_word", cif.cmd_data, sb.pop_front());
          rnack = (entry == nack_e) && (nacks < nack_n);
          if (rnack) nacks++;
          rdly = 2;
          if (entry == stop_e) stop_pend = 1'b1;
        end
      end else if (stalled > 0 && stalled < stall_n) begin
        stall_ok = 1'b0;
      end
    end
    check("serve_finished", ended, 1);
    if (stall_n > 0) check("stall_hold", stall_ok && (stalled == stall_n), 1);
  endtask

  initial begin
    int cyc;
    bit saw;
    cif.cmd_ready  = 1'b0;
    cif.resp_valid = 1'b0;
    cif.resp_nack  = 1'b0;

    // Reset state and power-up latency, then a clean all-ACK run.
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", cif.cmd_valid, 0);
    check("rst_cmd_data", cif.cmd_data, 16'h0000);
    check_status("rst", 1'b0, 1'b1, 1'b0, 0);
    rst_n = 1'b1;
    wait_first_valid(cyc);
    check("first_valid_cycle", cyc, PWR + 1);
    check("first_word", cif.cmd_data, 16'h1E00);
    push_seq(NONE, 0, LAST);
    serve(NONE, 0, NONE, 0, NONE, NONE, 1'b1);
    check("sb_empty_a", sb.size(), 0);
    check_status("run_a", 1'b1, 1'b0, 1'b0, LAST);
    repeat (30) @(negedge clk);
    check_status("done_hold", 1'b1, 1'b0, 1'b0, LAST);

    // Rerun from DONE with ready stalled on entry 3 and a start while busy.
    pulse_start();
    push_seq(NONE, 0, LAST);
    serve(3, 50, NONE, 0, NONE, 4, 1'b0);
    check("sb_empty_b", sb.size(), 0);
    check_status("run_b", 1'b1, 1'b0, 1'b0, LAST);

    // Two NACKs on entry 5 are retried and the run still completes.
    pulse_start();
    push_seq(5, 2, LAST);
    serve(NONE, 0, 5, 2, NONE, NONE, 1'b0);
    check("sb_empty_c", sb.size(), 0);
    check_status("run_c", 1'b1, 1'b0, 1'b0, LAST);

    // Four NACKs on entry 2 exhaust the retries.
    pulse_start();
    push_seq(2, 4, 2);
    serve(NONE, 0, 2, 4, NONE, NONE, 1'b0);
    check("sb_empty_d", sb.size(), 0);
    check_status("run_fail", 1'b0, 1'b0, 1'b1, 2);
    saw = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (cif.cmd_valid) saw = 1'b1;
    end
    check("fail_no_cmd_valid", saw, 0);
    pulse_start();
    push_seq(NONE, 0, LAST);
    serve(NONE, 0, NONE, 0, NONE, NONE, 1'b0);
    check("sb_empty_d2", sb.size(), 0);
    check_status("run_after_fail", 1'b1, 1'b0, 1'b0, LAST);

    // Reset while waiting for the response of entry 7.
    pulse_start();
    push_seq(NONE, 0, LAST);
    serve(NONE, 0, NONE, 0, 7, NONE, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cmd_valid", cif.cmd_valid, 0);
    check_status("abort", 1'b0, 1'b1, 1'b0, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wait_first_valid(cyc);
    check("rerst_valid_cycle", cyc, PWR + 1);
    check("rerst_first_word", cif.cmd_data, 16'h1E00);
    push_seq(NONE, 0, LAST);
    serve(NONE, 0, NONE, 0, NONE, NONE, 1'b0);
    check("sb_empty_e", sb.size(), 0);
    check_status("run_e", 1'b1, 1'b0, 1'b0, LAST);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
